// File: rtl/convertidor_ancho_pkg.sv
// ---------------------------------------------------------------------------
// convertidor_ancho_pkg
// Shared PHY width-conversion types, default widths and segment-count helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package convertidor_ancho_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 8;

  // Active segments for a width selector; never fewer than one.
  function automatic int seg_count(input int sel, input int n_seg);
    int c;
    c = (sel >= 32) ? 0 : (n_seg >> sel);
    return (c == 0) ? 1 : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/convertidor_ancho_ctl.sv
// ---------------------------------------------------------------------------
// convertidor_ancho_ctl
// Handshake FSM and remaining-segment counter; issues load/advance strobes.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module convertidor_ancho_ctl
  import convertidor_ancho_pkg::*;
#(
  parameter int N_SEG = 4,
  parameter int SEL_W = 2,
  parameter int IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [SEL_W-1:0] WIDTH_SEL,
  input  logic             IN_VALID,
  input  logic             OUT_READY,
  output logic             IN_READY,
  output logic             out_valid,
  output logic             out_last,
  output logic [IDX_W-1:0] seg_idx,
  output logic             load,
  output logic             advance
);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_seg, w_seg_nxt;
  logic [IDX_W-1:0] w_seg_first;
  logic             w_seg_zero;

  assign w_seg_first = IDX_W'(seg_count(int'(WIDTH_SEL), N_SEG) - 1);
  assign w_seg_zero  = (r_seg == '0);

  assign out_valid = (r_state == SEND);
  assign out_last  = out_valid & w_seg_zero;
  assign seg_idx   = r_seg;

  // Ready depends on OUT_READY only, never on IN_VALID.
  assign IN_READY = RESET_L & ENB & ((r_state == IDLE) | (out_valid & OUT_READY & w_seg_zero));
  assign load     = IN_VALID & IN_READY;
  assign advance  = ENB & out_valid & OUT_READY & ~w_seg_zero;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= IDLE;
      r_seg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = r_seg;
    if (!ENB) begin
      w_state_nxt = IDLE;
      w_seg_nxt   = '0;
    end else if (load) begin
      w_state_nxt = SEND;
      w_seg_nxt   = w_seg_first;
    end else if (advance) begin
      w_seg_nxt   = r_seg - 1'b1;
    end else if (out_valid & OUT_READY) begin
      w_state_nxt = IDLE;
      w_seg_nxt   = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/convertidor_ancho.sv
// ---------------------------------------------------------------------------
// convertidor_ancho
// Parallel-to-narrow width converter, MS active segment first, with backpressure.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module convertidor_ancho
  import convertidor_ancho_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SEL_W = 2,
  localparam int N_SEG = IN_W / OUT_W,
  localparam int IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [SEL_W-1:0] WIDTH_SEL,
  input  logic [IN_W-1:0]  IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_LAST,
  output logic [IDX_W-1:0] SEG_IDX
);

  logic [IN_W-1:0]  r_word;
  logic             w_load, w_advance, w_valid;
  logic [IDX_W-1:0] w_seg_idx;

  convertidor_ancho_ctl #(
    .N_SEG (N_SEG),
    .SEL_W (SEL_W),
    .IDX_W (IDX_W)
  ) u_ctl (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .ENB       (ENB),
    .WIDTH_SEL (WIDTH_SEL),
    .IN_VALID  (IN_VALID),
    .OUT_READY (OUT_READY),
    .IN_READY  (IN_READY),
    .out_valid (w_valid),
    .out_last  (OUT_LAST),
    .seg_idx   (w_seg_idx),
    .load      (w_load),
    .advance   (w_advance)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L)
      r_word <= '0;
    else if (!ENB)
      r_word <= '0;
    else if (w_load)
      r_word <= IN_DATA;
  end

  // Counter value doubles as the segment index; idle output is forced to zero.
  assign OUT_DATA  = w_valid ? r_word[w_seg_idx*OUT_W +: OUT_W] : '0;
  assign OUT_VALID = w_valid;
  assign SEG_IDX   = w_seg_idx;

endmodule

`default_nettype wire

// File: tb/tb_convertidor_ancho.sv
// ---------------------------------------------------------------------------
// tb_convertidor_ancho
// Directed self-checking bench for the 32-to-8 configuration.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_convertidor_ancho;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        ENB;
  logic [1:0]  WIDTH_SEL;
  logic [31:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_LAST;
  logic [1:0]  SEG_IDX;

  int checks = 0;
  int errors = 0;

  convertidor_ancho #(
    .IN_W  (32),
    .OUT_W (8),
    .SEL_W (2)
  ) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .ENB       (ENB),
    .WIDTH_SEL (WIDTH_SEL),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_LAST  (OUT_LAST),
    .SEG_IDX   (SEG_IDX)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks the presented segment, then lets one clock edge pass.
  task automatic expect_seg(input string tag, input logic [7:0] d, input logic [1:0] idx,
                            input logic last);
    #1;
    check({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd1);
    check({tag, "_data"},  {24'd0, OUT_DATA},  {24'd0, d});
    check({tag, "_idx"},   {30'd0, SEG_IDX},   {30'd0, idx});
    check({tag, "_last"},  {31'd0, OUT_LAST},  {31'd0, last});
    tick();
  endtask

  task automatic expect_idle(input string tag);
    #1;
    check({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
    check({tag, "_data"},  {24'd0, OUT_DATA},  32'd0);
    check({tag, "_last"},  {31'd0, OUT_LAST},  32'd0);
  endtask

  // Presents a word for one accepting edge; first segment is shown afterwards.
  task automatic send_word(input logic [31:0] w, input logic [1:0] sel);
    IN_DATA   = w;
    WIDTH_SEL = sel;
    IN_VALID  = 1'b1;
    tick();
    IN_VALID  = 1'b0;
    IN_DATA   = 32'hFFFF_FFFF;
    WIDTH_SEL = 2'd3;
  endtask

  initial begin
    RESET_L   = 1'b0;
    ENB       = 1'b0;
    WIDTH_SEL = 2'd0;
    IN_DATA   = 32'd0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, IN_READY}, 32'd0);
    expect_idle("rst");
    check("rst_idx", {30'd0, SEG_IDX}, 32'd0);
    tick();
    tick();
    RESET_L   = 1'b1;
    ENB       = 1'b1;
    OUT_READY = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);
    tick();

    // Full-width word
    send_word(32'hA1B2C3D4, 2'd0);
    expect_seg("w0_a1", 8'hA1, 2'd3, 1'b0);
    expect_seg("w0_b2", 8'hB2, 2'd2, 1'b0);
    expect_seg("w0_c3", 8'hC3, 2'd1, 1'b0);
    #1;
    check("w0_d4_in_ready", {31'd0, IN_READY}, 32'd1);
    expect_seg("w0_d4", 8'hD4, 2'd0, 1'b1);
    expect_idle("w0_end");
    tick();

    // Reduced widths
    send_word(32'h1234ABCD, 2'd1);
    expect_seg("s1_ab", 8'hAB, 2'd1, 1'b0);
    expect_seg("s1_cd", 8'hCD, 2'd0, 1'b1);
    expect_idle("s1_end");
    tick();
    send_word(32'h1234ABCD, 2'd2);
    expect_seg("s2_cd", 8'hCD, 2'd0, 1'b1);
    expect_idle("s2_end");
    tick();
    send_word(32'h1234ABCD, 2'd3);
    expect_seg("s3_cd", 8'hCD, 2'd0, 1'b1);
    expect_idle("s3_end");
    tick();

    // Back-to-back words without a bubble
    IN_DATA   = 32'h01020304;
    WIDTH_SEL = 2'd0;
    IN_VALID  = 1'b1;
    tick();
    IN_DATA   = 32'h05060708;
    expect_seg("bb_01", 8'h01, 2'd3, 1'b0);
    expect_seg("bb_02", 8'h02, 2'd2, 1'b0);
    expect_seg("bb_03", 8'h03, 2'd1, 1'b0);
    IN_VALID = 1'b0;
    #1;
    check("bb_04_in_ready", {31'd0, IN_READY}, 32'd1);
    IN_VALID = 1'b1;
    expect_seg("bb_04", 8'h04, 2'd0, 1'b1);
    IN_VALID = 1'b0;
    IN_DATA  = 32'hFFFF_FFFF;
    expect_seg("bb_05", 8'h05, 2'd3, 1'b0);
    expect_seg("bb_06", 8'h06, 2'd2, 1'b0);
    expect_seg("bb_07", 8'h07, 2'd1, 1'b0);
    expect_seg("bb_08", 8'h08, 2'd0, 1'b1);
    expect_idle("bb_end");
    tick();

    // Backpressure on B2
    send_word(32'hA1B2C3D4, 2'd0);
    expect_seg("bp_a1", 8'hA1, 2'd3, 1'b0);
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_seg("bp_hold", 8'hB2, 2'd2, 1'b0);
    end
    OUT_READY = 1'b1;
    expect_seg("bp_b2", 8'hB2, 2'd2, 1'b0);
    // Flush while C3 is presented
    #1;
    check("fl_c3_data", {24'd0, OUT_DATA}, 32'h0000_00C3);
    ENB = 1'b0;
    #1;
    check("fl_in_ready_now", {31'd0, IN_READY}, 32'd0);
    tick();
    expect_idle("fl");
    check("fl_in_ready", {31'd0, IN_READY}, 32'd0);
    tick();
    ENB = 1'b1;
    send_word(32'hDEADBEEF, 2'd0);
    expect_seg("nw_de", 8'hDE, 2'd3, 1'b0);
    expect_seg("nw_ad", 8'hAD, 2'd2, 1'b0);
    expect_seg("nw_be", 8'hBE, 2'd1, 1'b0);
    expect_seg("nw_ef", 8'hEF, 2'd0, 1'b1);
    expect_idle("nw_end");
    tick();

    // Asynchronous reset mid-word, away from any clock edge
    send_word(32'hA1B2C3D4, 2'd0);
    #2;
    check("ar_pre_valid", {31'd0, OUT_VALID}, 32'd1);
    RESET_L = 1'b0;
    #1;
    expect_idle("ar");
    check("ar_idx", {30'd0, SEG_IDX}, 32'd0);
    check("ar_in_ready", {31'd0, IN_READY}, 32'd0);
    tick();
    RESET_L = 1'b1;
    #1;
    check("ar_rel_in_ready", {31'd0, IN_READY}, 32'd1);
    check("ar_rel_valid", {31'd0, OUT_VALID}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
